// File: rtl/code_rom_pkg.sv
// Shared types and constants for the debug-harness code ROM loader.
// Holds the loader state encoding, the error codes reported to the host
// and the default frame start marker.
package code_rom_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/code_rom_wdog.sv
// Inter-byte watchdog: counts idle cycles while run is high, saturating at the limit.
// Latency: expired asserts the cycle the count register equals TIMEOUT_CYCLES.
// Backpressure: none; clear has priority over counting.
// Ports: clk, reset_code_rom_n (async low), run, clear -> expired.
module code_rom_wdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset_code_rom_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/code_rom_loader.sv
// Framed byte-stream writer for the debug harness code ROM (SYNC, LEN_LO, LEN_HI, payload, CSUM).
// Latency: a payload byte accepted at edge N is strobed to the ROM during cycle N+1.
// Backpressure: s_ready drops for the strobe cycle after each payload byte and in DONE/ERROR.
// Ports: clk, reset_code_rom_n, s_valid/s_data/s_ready host link; rom_prog_mode/rom_addr/rom_data
//        ROM write port; dut_rst_n, load_busy, load_done, load_error, err_code status.
module code_rom_loader
    import code_rom_pkg::*;
#(
    parameter int         ROM_DEPTH      = 4096,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_code_rom_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        rom_prog_mode,
    output logic [11:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        dut_rst_n,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_error,
    output logic [1:0]  err_code
);

    localparam logic [12:0] DEPTH13 = 13'(ROM_DEPTH);

    loader_state_t state;
    logic [7:0]    len_lo;
    logic [11:0]   len;
    logic [11:0]   idx;
    logic [7:0]    sum;
    logic [1:0]    err_pend;

    logic        xfer;
    logic        in_frame;
    logic        expired;
    logic [11:0] len_rx;
    logic        len_bad;
    logic [7:0]  csum_total;
    logic        last_byte;

    assign xfer       = s_valid && s_ready;
    assign in_frame   = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
    assign len_rx     = {s_data[3:0], len_lo};
    assign len_bad    = (s_data[7:4] != 4'h0) || (len_rx == 12'd0) || ({1'b0, len_rx} > DEPTH13);
    assign csum_total = sum + s_data;
    assign last_byte  = (idx == (len - 12'd1));

    code_rom_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk              (clk),
        .reset_code_rom_n (reset_code_rom_n),
        .run              (in_frame),
        .clear            (xfer || !in_frame),
        .expired          (expired)
    );

    always_ff @(posedge clk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            state         <= IDLE;
            s_ready       <= 1'b0;
            rom_prog_mode <= 1'b0;
            rom_addr      <= '0;
            rom_data      <= '0;
            dut_rst_n     <= 1'b1;
            load_busy     <= 1'b0;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            err_code      <= ERR_NONE;
            err_pend      <= ERR_NONE;
            len_lo        <= '0;
            len           <= '0;
            idx           <= '0;
            sum           <= '0;
        end else begin
            rom_prog_mode <= 1'b0;
            load_done     <= 1'b0;
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (xfer && (s_data == SYNC_BYTE)) begin
                        load_error <= 1'b0;
                        err_code   <= ERR_NONE;
                        load_busy  <= 1'b1;
                        dut_rst_n  <= 1'b0;
                        state      <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len_lo <= s_data;
                        state  <= LEN_HI;
                    end else if (expired) begin
                        err_pend <= ERR_TIMEOUT;
                        s_ready  <= 1'b0;
                        state    <= ERROR;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        if (len_bad) begin
                            err_pend <= ERR_LEN;
                            s_ready  <= 1'b0;
                            state    <= ERROR;
                        end else begin
                            len   <= len_rx;
                            idx   <= '0;
                            sum   <= '0;
                            state <= DATA;
                        end
                    end else if (expired) begin
                        err_pend <= ERR_TIMEOUT;
                        s_ready  <= 1'b0;
                        state    <= ERROR;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        // Drop ready for the strobe cycle so strobes can never be back to back.
                        s_ready       <= 1'b0;
                        rom_prog_mode <= 1'b1;
                        rom_addr      <= idx;
                        rom_data      <= s_data;
                        idx           <= idx + 12'd1;
                        sum           <= csum_total;
                        if (last_byte) begin
                            state <= CSUM;
                        end
                    end else begin
                        s_ready <= 1'b1;
                        if (expired) begin
                            err_pend <= ERR_TIMEOUT;
                            s_ready  <= 1'b0;
                            state    <= ERROR;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        s_ready <= 1'b0;
                        if (csum_total == 8'h00) begin
                            state <= DONE;
                        end else begin
                            err_pend <= ERR_CSUM;
                            state    <= ERROR;
                        end
                    end else begin
                        s_ready <= 1'b1;
                        if (expired) begin
                            err_pend <= ERR_TIMEOUT;
                            s_ready  <= 1'b0;
                            state    <= ERROR;
                        end
                    end
                end
                DONE: begin
                    load_done <= 1'b1;
                    load_busy <= 1'b0;
                    dut_rst_n <= 1'b1;
                    s_ready   <= 1'b1;
                    state     <= IDLE;
                end
                ERROR: begin
                    load_error <= 1'b1;
                    err_code   <= err_pend;
                    load_busy  <= 1'b0;
                    dut_rst_n  <= 1'b1;
                    s_ready    <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    s_ready <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_rom_loader.sv
// Directed plus randomized frames against a frame-parsing reference model.
module tb_code_rom_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        reset_code_rom_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        rom_prog_mode;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        dut_rst_n;
    logic        load_busy;
    logic        load_done;
    logic        load_error;
    logic [1:0]  err_code;

    int vectors     = 0;
    int miscompares = 0;

    logic [19:0] wq[$];
    logic [19:0] exp_wq[$];
    int          done_cnt;
    int          exp_done;
    int          exp_err;
    logic        prev_pm;

    code_rom_loader #(
        .ROM_DEPTH      (4096),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .reset_code_rom_n (reset_code_rom_n),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .rom_prog_mode    (rom_prog_mode),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .dut_rst_n        (dut_rst_n),
        .load_busy        (load_busy),
        .load_done        (load_done),
        .load_error       (load_error),
        .err_code         (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Capture ROM writes and done pulses; every strobe must sit inside a frame and be isolated.
    always @(negedge clk) begin
        if (reset_code_rom_n) begin
            if (rom_prog_mode) begin
                wq.push_back({rom_addr, rom_data});
                chk("strobe_dut_in_reset", {31'd0, dut_rst_n}, 32'd0);
                chk("strobe_spacing", {31'd0, prev_pm}, 32'd0);
            end
            if (load_done) done_cnt++;
            prev_pm = rom_prog_mode;
        end else begin
            prev_pm = 1'b0;
        end
    end

    // Reference: locate the SYNC byte, then read length, payload and checksum by position.
    // A stream that ends before the frame is complete is expected to time out.
    task automatic model(input bq_t b);
        int i;
        int len;
        int s;
        exp_wq.delete();
        exp_done = 0;
        exp_err  = 0;
        i = 0;
        while (i < b.size() && b[i] != 8'hA5) i++;
        if (i + 2 >= b.size()) begin exp_err = 3; return; end
        len = int'(b[i+1]) + 256 * int'(b[i+2][3:0]);
        if (b[i+2][7:4] != 4'h0 || len == 0 || len > 4096) begin exp_err = 1; return; end
        s = 0;
        for (int k = 0; k < len; k++) begin
            if (i + 3 + k >= b.size()) begin exp_err = 3; return; end
            exp_wq.push_back({12'(k), b[i+3+k]});
            s += int'(b[i+3+k]);
        end
        if (i + 3 + len >= b.size()) begin exp_err = 3; return; end
        if (((s + int'(b[i+3+len])) % 256) == 0) exp_done = 1;
        else exp_err = 2;
    endtask

    task automatic send(input bq_t b, input int maxgap);
        int g;
        int guard;
        bit acc;
        foreach (b[k]) begin
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (g) begin @(negedge clk); s_valid = 1'b0; end
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 64) begin
                @(negedge clk);
                s_valid = 1'b1;
                s_data  = b[k];
                acc     = s_ready;
                guard++;
            end
            if (!acc) chk("accept_bound", 32'd0, 32'd1);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic run_frame(input bq_t b, input int maxgap);
        wq.delete();
        done_cnt = 0;
        model(b);
        send(b, maxgap);
        repeat (40) @(negedge clk);
        chk("n_strobes", wq.size(), exp_wq.size());
        for (int k = 0; k < exp_wq.size() && k < wq.size(); k++)
            chk("strobe_addr_data", {12'd0, wq[k]}, {12'd0, exp_wq[k]});
        chk("done_pulses", done_cnt, exp_done);
        chk("load_error", {31'd0, load_error}, (exp_err != 0) ? 32'd1 : 32'd0);
        chk("err_code", {30'd0, err_code}, exp_err);
        chk("dut_rst_n_idle", {31'd0, dut_rst_n}, 32'd1);
        chk("load_busy_idle", {31'd0, load_busy}, 32'd0);
    endtask

    task automatic check_reset_values();
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_prog_mode", {31'd0, rom_prog_mode}, 32'd0);
        chk("rst_rom_addr", {20'd0, rom_addr}, 32'd0);
        chk("rst_rom_data", {24'd0, rom_data}, 32'd0);
        chk("rst_dut_rst_n", {31'd0, dut_rst_n}, 32'd1);
        chk("rst_load_busy", {31'd0, load_busy}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_load_error", {31'd0, load_error}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
    endtask

    function automatic bq_t rand_frame(input bit bad_csum);
        bq_t f;
        int  len;
        int  s;
        logic [7:0] d;
        len = int'($urandom_range(20, 1));
        f = '{8'hA5, 8'(len), 8'h00};
        s = 0;
        for (int k = 0; k < len; k++) begin
            d = 8'($urandom);
            f.push_back(d);
            s += int'(d);
        end
        d = 8'((256 - (s % 256)) % 256);
        if (bad_csum) d = d + 8'd1;
        f.push_back(d);
        return f;
    endfunction

    initial begin
        bq_t b;
        reset_code_rom_n = 1'b0;
        s_valid          = 1'b0;
        s_data           = 8'h00;
        done_cnt         = 0;
        prev_pm          = 1'b0;

        // Reset values, then ready in the first cycle after release.
        #12;
        check_reset_values();
        @(negedge clk);
        reset_code_rom_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, s_ready}, 32'd1);

        // Good frame, back-to-back bytes.
        b = '{8'hA5, 8'h08, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h4A};
        run_frame(b, 0);

        // Same frame, checksum off by one.
        b = '{8'hA5, 8'h08, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h4B};
        run_frame(b, 0);

        // Zero length and length with nonzero upper nibble.
        b = '{8'hA5, 8'h00, 8'h00};
        run_frame(b, 0);
        b = '{8'hA5, 8'h01, 8'h10};
        run_frame(b, 0);

        // Host stalls mid-payload until the watchdog fires.
        b = '{8'hA5, 8'h04, 8'h00, 8'h11};
        run_frame(b, 0);

        // Leading junk then random frames with random valid gaps; one has a bad checksum.
        for (int it = 0; it < 4; it++) begin
            b = '{8'h00, 8'hFF, 8'hA4};
            b = {b, rand_frame(it == 2)};
            run_frame(b, 3);
        end

        // Reset pulsed during payload, then a clean reload.
        b = '{8'hA5, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03};
        send(b, 0);
        chk("busy_mid_frame", {31'd0, load_busy}, 32'd1);
        chk("dut_held_mid_frame", {31'd0, dut_rst_n}, 32'd0);
        #2;
        reset_code_rom_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        reset_code_rom_n = 1'b1;
        run_frame(rand_frame(1'b0), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
